// File: rtl/stride_permutation_stream.sv
// stride_permutation_stream
//   Streaming stride permutation for the NTT datapath. A block of BLOCK_SIZE
//   words arrives INPUT_PER_CYCLE words per beat. It is emitted reordered so
//   that output word j takes input word rotr_LOG_N(j, k). The exponent k is
//   chosen per block, and any k >= LOG_N behaves as k = 0.
//   Two banks alternate, so back-to-back blocks stream with no stall and no gap.
//   Optional feature macro: STRIDE_PERM_ERR_EN adds the sticky err_overrun flag.
`timescale 1ns/1ps

module stride_permutation_stream #(
  parameter  int DATA_WIDTH_PER_INPUT = 28,
  parameter  int INPUT_PER_CYCLE      = 64,
  parameter  int BLOCK_SIZE           = 1024,
  localparam int DEPTH                = BLOCK_SIZE / INPUT_PER_CYCLE,
  localparam int LOG_N                = $clog2(BLOCK_SIZE),
  localparam int STAGE_W              = $clog2(LOG_N),
  localparam int DATA_W               = DATA_WIDTH_PER_INPUT * INPUT_PER_CYCLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [STAGE_W-1:0] cfg_stage,
  output logic               out_start,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
`ifdef STRIDE_PERM_ERR_EN
  ,
  output logic               err_overrun
`endif
);

  localparam int W      = DATA_WIDTH_PER_INPUT;
  localparam int P      = INPUT_PER_CYCLE;
  localparam int N      = BLOCK_SIZE;
  localparam int BEAT_W = $clog2(DEPTH);
  localparam int LANE_W = $clog2(P);

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_t;

  // Flat word address of (beat, lane). P is a power of two, so this is {beat, lane}.
  function automatic logic [LOG_N-1:0] word_addr(input logic [BEAT_W-1:0] beat,
                                                 input int                lane);
    return (LOG_N'(beat) << LANE_W) | LOG_N'(lane);
  endfunction

  // Rotate right by k within LOG_N bits. This maps an output index to its source index.
  function automatic logic [LOG_N-1:0] rotr(input logic [LOG_N-1:0]   v,
                                            input logic [STAGE_W-1:0] k);
    logic [2*LOG_N-1:0] dbl;
    dbl = {v, v} >> k;
    return dbl[LOG_N-1:0];
  endfunction

  // Two banks of one block each
  logic [W-1:0]       r_mem [2][N];

  // Write side
  wr_state_t          r_wr_state;
  wr_state_t          w_wr_state_nxt;
  logic [BEAT_W-1:0]  r_wr_cnt;
  logic               r_wr_bank;
  logic [STAGE_W-1:0] r_k [2];
  logic               w_wr_en;
  logic [BEAT_W-1:0]  w_wr_beat;
  logic               w_wr_last;
  logic [STAGE_W-1:0] w_k_in;

  // Read side
  logic [1:0]         r_full;
  logic [1:0]         w_full_nxt;
  logic               r_rd_bank;
  logic [BEAT_W-1:0]  r_rd_cnt;
  logic               w_rd_active;
  logic               w_rd_last;
  logic [DATA_W-1:0]  w_perm;

  // Output registers
  logic               r_out_start;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;

  // An out-of-range exponent collapses to identity before it is latched.
  assign w_k_in = (int'(cfg_stage) < LOG_N) ? cfg_stage : '0;

  // Write FSM state register
  // NOTE: state and counters use non-blocking (<=) assignments. Every flop then
  // samples pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_state <= WR_IDLE;
    else      r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM next state and beat decode. A new in_start always wins and restarts at beat 0.
  // NOTE: every signal assigned here gets a default on the first lines. Otherwise
  // a path that skips an assignment would infer a latch.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_en        = 1'b0;
    w_wr_beat      = r_wr_cnt;
    w_wr_last      = 1'b0;
    if (in_start) begin
      w_wr_en        = 1'b1;
      w_wr_beat      = '0;
      w_wr_state_nxt = WR_FILL;
    end else begin
      case (r_wr_state)
        WR_FILL: begin
          w_wr_en = 1'b1;
          if (r_wr_cnt == BEAT_W'(DEPTH - 1)) begin
            w_wr_last      = 1'b1;
            w_wr_state_nxt = WR_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Write beat counter, bank pointer and per-bank stride exponent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_k[0]    <= '0;
      r_k[1]    <= '0;
    end else if (in_start) begin
      r_wr_cnt       <= BEAT_W'(1);
      r_k[r_wr_bank] <= w_k_in;
    end else if (w_wr_last) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= ~r_wr_bank;
    end else if (w_wr_en) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  // Bank storage writes in natural order
  // NOTE: the storage has no reset. The full flags gate every read, so stale
  // words are never visible. A reset term would also prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int l = 0; l < P; l++) begin
        r_mem[r_wr_bank][word_addr(w_wr_beat, l)] <= in_data[l*W +: W];
      end
    end
  end

  assign w_rd_active = r_full[r_rd_bank];
  assign w_rd_last   = w_rd_active && (r_rd_cnt == BEAT_W'(DEPTH - 1));

  // Full flags: the reader releases its bank and the writer claims the other bank.
  // Both can happen in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Read pointer and beat counter. The pointer flips on the last beat, so a bank
  // that is already full is read on the very next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full    <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_rd_last) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else if (w_rd_active) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // Combinational permuted read of the current output beat
  always_comb begin
    w_perm = '0;
    for (int l = 0; l < P; l++) begin
      w_perm[l*W +: W] = r_mem[r_rd_bank][rotr(word_addr(r_rd_cnt, l), r_k[r_rd_bank])];
    end
  end

  // Output register. Data holds its last value while no block is being read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_rd_active) begin
      r_out_start <= (r_rd_cnt == '0);
      r_out_valid <= 1'b1;
      r_out_data  <= w_perm;
    end else begin
      r_out_start <= 1'b0;
      r_out_valid <= 1'b0;
    end
  end

  assign out_start = r_out_start;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_wr_state == WR_FILL) | (in_start & rst);

`ifdef STRIDE_PERM_ERR_EN
  logic w_abandon;
  logic r_err_overrun;

  assign w_abandon = in_start && (r_wr_state == WR_FILL);

  // Sticky flag: set when a partially collected block is abandoned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err_overrun <= 1'b0;
    else if (w_abandon) r_err_overrun <= 1'b1;
  end

  assign err_overrun = r_err_overrun;
`endif

endmodule

// File: tb/tb_stride_permutation_stream.sv
// tb_stride_permutation_stream
//   Drives ramp and random blocks, each with its own stride exponent. Every
//   output beat is compared with a reference built from the index rule
//   out[j] = in[rotr(j, k)]. The reference also gives each beat the cycle on
//   which it must appear.
`timescale 1ns/1ps

module tb_stride_permutation_stream;

  localparam int W       = 28;
  localparam int P       = 64;
  localparam int N       = 1024;
  localparam int DEPTH   = N / P;
  localparam int LOG_N   = 10;
  localparam int STAGE_W = 4;
  localparam int BW      = P * W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_start;
  logic [BW-1:0]      in_data;
  logic [STAGE_W-1:0] cfg_stage;
  logic               out_start;
  logic               out_valid;
  logic [BW-1:0]      out_data;
  logic               busy;
`ifdef STRIDE_PERM_ERR_EN
  logic               err_overrun;
`endif

  stride_permutation_stream #(
    .DATA_WIDTH_PER_INPUT(W),
    .INPUT_PER_CYCLE     (P),
    .BLOCK_SIZE          (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_start   (in_start),
    .in_data    (in_data),
    .cfg_stage  (cfg_stage),
    .out_start  (out_start),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
`ifdef STRIDE_PERM_ERR_EN
    ,
    .err_overrun(err_overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int            cyc;
    int            beat;
    logic [BW-1:0] data;
  } exp_beat_t;

  exp_beat_t     exp_q[$];
  exp_beat_t     mon_e;
  logic [BW-1:0] last_exp = '0;
  int            last_x;

  // Source index for output word j under exponent k. Exponents outside the legal range mean identity.
  function automatic int src_of(input int j, input int k);
    int ke;
    ke = (k < LOG_N) ? k : 0;
    if (ke == 0) return j;
    return ((j >> ke) | (j << (LOG_N - ke))) & (N - 1);
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    v = '0;
    for (int l = 0; l < P; l++) v[l*W +: W] = W'($urandom);
    return v;
  endfunction

  // Sends nbeats beats of a block. A full block pushes its expected output.
  task automatic drive_block(input int k, input bit ramp, input int base, input int nbeats);
    logic [W-1:0]  words [N];
    logic [BW-1:0] v;
    exp_beat_t     e;
    int            x;
    x = 0;
    for (int i = 0; i < N; i++) words[i] = ramp ? W'(base + i) : W'($urandom);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == 0) x = cyc;
      for (int l = 0; l < P; l++) v[l*W +: W] = words[b*P + l];
      in_data   = v;
      in_start  = (b == 0);
      cfg_stage = (b == 0) ? STAGE_W'(k) : STAGE_W'($urandom);
      #1 check($sformatf("busy beat %0d", b), busy, 1);
    end
    last_x = x;
    if (nbeats == DEPTH) begin
      for (int b = 0; b < DEPTH; b++) begin
        e.cyc  = x + 1 + DEPTH + b;
        e.beat = b;
        for (int l = 0; l < P; l++) e.data[l*W +: W] = words[src_of(b*P + l, k)];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_start  = 1'b0;
      in_data   = rand_beat();
      cfg_stage = STAGE_W'($urandom);
      #1 check("busy idle", busy, 0);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("beat %0d cycle", mon_e.beat), cyc, mon_e.cyc);
          check($sformatf("beat %0d out_start", mon_e.beat), out_start, mon_e.beat == 0);
          for (int l = 0; l < P; l++)
            check($sformatf("data b%0d l%0d", mon_e.beat, l), out_data[l*W +: W], mon_e.data[l*W +: W]);
          last_exp = mon_e.data;
        end
      end else begin
        int nd;
        nd = 0;
        for (int l = 0; l < P; l++) if (out_data[l*W +: W] !== last_exp[l*W +: W]) nd++;
        check("out_data hold (lanes differing)", nd, 0);
        if (out_start) check("out_start without valid", out_start, 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check($sformatf("missing beat %0d", exp_q[0].beat), out_valid, 1);
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    int nd;
    rst       = 1'b1;
    in_start  = 1'b0;
    in_data   = '0;
    cfg_stage = '0;
    #1 rst = 1'b0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset out_start", out_start, 0);
    check("reset out_data nonzero", out_data != '0, 0);
    check("reset busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(3);
`ifdef STRIDE_PERM_ERR_EN
    check("err_overrun after reset", err_overrun, 0);
`endif

    // Identity, then two strides, on a ramp
    drive_block(0, 1'b1, 0, DEPTH);
    idle(DEPTH + 4);
    drive_block(6, 1'b1, 0, DEPTH);
    idle(DEPTH + 4);
    drive_block(9, 1'b1, 0, DEPTH);
    idle(DEPTH + 4);

    // Back-to-back: k=6 ramp, then k=0 ramp offset by N
    drive_block(6, 1'b1, 0, DEPTH);
    drive_block(0, 1'b1, N, DEPTH);
    idle(2 * DEPTH + 4);
`ifdef STRIDE_PERM_ERR_EN
    check("err_overrun before abandon", err_overrun, 0);
`endif

    // Restart at beat 5: only the second block may appear
    drive_block(3, 1'b0, 0, 5);
    drive_block(0, 1'b1, 0, DEPTH);
    idle(DEPTH + 4);
`ifdef STRIDE_PERM_ERR_EN
    check("err_overrun after abandon", err_overrun, 1);
`endif

    // in_start lands on the would-be last beat
    drive_block(5, 1'b0, 0, DEPTH - 1);
    drive_block(7, 1'b0, 0, DEPTH);
    idle(DEPTH + 4);

    // Abandon while the other bank is being read
    drive_block(2, 1'b0, 0, DEPTH);
    drive_block(4, 1'b0, 0, 5);
    drive_block(8, 1'b0, 0, DEPTH);
    idle(2 * DEPTH + 4);

    // Out-of-range exponents act as identity
    drive_block(12, 1'b1, 0, DEPTH);
    drive_block(15, 1'b1, N, DEPTH);
    idle(2 * DEPTH + 4);

    // Random blocks, random exponents, random gaps
    for (int n = 0; n < 8; n++) begin
      drive_block(int'($urandom_range(0, 15)), 1'b0, 0, DEPTH);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2 * DEPTH + 4);

    // Reset during output beat 8
    drive_block(1, 1'b0, 0, DEPTH);
    while (cyc < last_x + DEPTH + 9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_start", out_start, 0);
    nd = 0;
    for (int l = 0; l < P; l++) if (out_data[l*W +: W] !== '0) nd++;
    check("async reset out_data (lanes nonzero)", nd, 0);
`ifdef STRIDE_PERM_ERR_EN
    check("err_overrun cleared", err_overrun, 0);
`endif
    exp_q.delete();
    last_exp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(3 * DEPTH);

    // A fresh block after reset
    drive_block(4, 1'b0, 0, DEPTH);
    idle(DEPTH + 4);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
